// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: access sizes, FSM states,
// big-endian lane selection and alignment checks.
package mem_pkg;

  typedef enum logic [1:0] {
    WORD = 2'd0,
    BYTE = 2'd1,
    HALF = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_t;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] sz);
    case (sz)
      2'b01:   decode_size = BYTE;
      2'b10:   decode_size = HALF;
      default: decode_size = WORD;
    endcase
  endfunction

  // Bit 3 of the mask is lane 0 (bits 31:24), so address 00 hits the MSB lane.
  function automatic logic [3:0] lane_mask(input mem_size_t sz, input logic [1:0] a);
    case (sz)
      BYTE:    lane_mask = 4'b1000 >> a;
      HALF:    lane_mask = a[1] ? 4'b0011 : 4'b1100;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] a);
    case (sz)
      BYTE:    is_misaligned = 1'b0;
      HALF:    is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Four 8-bit lanes of DEPTH_WORDS entries with per-lane write enables.
// Write and registered read both happen on the clock edge where they are enabled.
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (we_i[i]) mem[addr_i] <= wdata_i[8*i +: 8];
      if (re_i)    rd_q        <= mem[addr_i];
    end

    assign rdata_o[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures a request, inserts WAIT_CYCLES wait states,
// commits the access on the edge entering RESP and pulses ready for one cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] Address,
  input  logic [1:0]  Size,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        ready,
  output logic        misaligned
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WLOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  resp_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap, commit;

  logic          wr_q;
  logic [AW+1:0] addr_q;
  mem_size_t     size_q;
  logic [31:0]   din_q;

  logic          mis_q, dzero_q;
  mem_size_t     rsize_q;
  logic [1:0]    rlane_q;

  logic          c_wr, c_mis;
  logic [AW+1:0] c_addr;
  mem_size_t     c_size;
  logic [31:0]   c_din, wdata, ram_rdata, byte_sh;
  logic [3:0]    we;
  logic          re;

  logic          unused_addr_hi;
  assign unused_addr_hi = ^Address[31:AW+2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap        = 1'b0;
    commit     = 1'b0;
    ready      = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cap = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WLOAD);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        ready      = 1'b1;
        misaligned = mis_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the capture edge, so the live
  // inputs stand in for the not-yet-loaded capture registers.
  always_comb begin
    c_wr   = (state_q == IDLE) ? wr                  : wr_q;
    c_addr = (state_q == IDLE) ? Address[AW+1:0]     : addr_q;
    c_size = (state_q == IDLE) ? decode_size(Size)   : size_q;
    c_din  = (state_q == IDLE) ? Datain              : din_q;
    c_mis  = is_misaligned(c_size, c_addr[1:0]);
    case (c_size)
      BYTE:    wdata = {4{c_din[7:0]}};
      HALF:    wdata = {2{c_din[15:0]}};
      default: wdata = c_din;
    endcase
    we = (commit && c_wr && !c_mis) ? lane_mask(c_size, c_addr[1:0]) : 4'b0000;
    re = commit && !c_wr && !c_mis;
  end

  byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i   (Clk),
    .addr_i  (c_addr[AW+1:2]),
    .we_i    (we),
    .wdata_i (wdata),
    .re_i    (re),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= WORD;
      din_q   <= '0;
      mis_q   <= 1'b0;
      dzero_q <= 1'b1;
      rsize_q <= WORD;
      rlane_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        wr_q   <= wr;
        addr_q <= Address[AW+1:0];
        size_q <= decode_size(Size);
        din_q  <= Datain;
      end
      if (commit) begin
        mis_q <= c_mis;
        if (c_mis) begin
          dzero_q <= 1'b1;
        end else if (!c_wr) begin
          dzero_q <= 1'b0;
          rsize_q <= c_size;
          rlane_q <= c_addr[1:0];
        end
      end
    end
  end

  // Steering uses the size/lane of the last read so writes never disturb Dataout.
  assign byte_sh = ram_rdata >> (5'd24 - {rlane_q, 3'b000});

  always_comb begin
    Dataout = '0;
    if (!dzero_q) begin
      case (rsize_q)
        BYTE:    Dataout = {24'd0, byte_sh[7:0]};
        HALF:    Dataout = rlane_q[1] ? {16'd0, ram_rdata[15:0]} : {16'd0, ram_rdata[31:16]};
        default: Dataout = ram_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with 3, 2 and 0 wait states.
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic [31:0] Address = '0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Datain = '0;
  logic        req_v [3];
  logic [31:0] dout [3];
  logic        rdy [3];
  logic        mis [3];

  int wc [3] = '{3, 2, 0};
  logic [31:0] mdout [3];

  typedef struct {
    logic [31:0] dat;
    logic        mis;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
    .Clk(Clk), .reset(reset), .req(req_v[0]), .wr(wr), .Address(Address), .Size(Size),
    .Datain(Datain), .Dataout(dout[0]), .ready(rdy[0]), .misaligned(mis[0]));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
    .Clk(Clk), .reset(reset), .req(req_v[1]), .wr(wr), .Address(Address), .Size(Size),
    .Datain(Datain), .Dataout(dout[1]), .ready(rdy[1]), .misaligned(mis[1]));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
    .Clk(Clk), .reset(reset), .req(req_v[2]), .wr(wr), .Address(Address), .Size(Size),
    .Datain(Datain), .Dataout(dout[2]), .ready(rdy[2]), .misaligned(mis[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic w, input logic [31:0] rd, input logic m);
    exp_t e;
    if (m)      e.dat = '0;
    else if (w) e.dat = mdout[i];
    else        e.dat = rd;
    e.mis    = m;
    e.lat    = 1 + wc[i];
    mdout[i] = e.dat;
    sb.push_back(e);
  endtask

  // One full transaction; rd is the expected read data (ignored for writes).
  task automatic do_txn(input int i, input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input logic [31:0] rd, input logic m, input string tag);
    int   lat;
    logic seen;
    exp_t e;
    @(negedge Clk);
    wr = w; Address = a; Size = sz; Datain = d; req_v[i] = 1'b1;
    push_exp(i, w, rd, m);
    @(posedge Clk);
    #1 req_v[i] = 1'b0;
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clk);
      lat++;
      if (rdy[i]) seen = 1'b1;
    end
    chk({tag, "_rdy"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_dat"}, dout[i], e.dat);
    chk({tag, "_mis"}, 32'(mis[i]), 32'(e.mis));
    @(negedge Clk);
    chk({tag, "_pulse"}, 32'(rdy[i]), 32'd0);
  endtask

  initial begin
    logic seen;
    exp_t e;
    for (int i = 0; i < 3; i++) begin req_v[i] = 1'b0; mdout[i] = '0; end
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("rst_mis%0d", i), 32'(mis[i]), 32'd0);
      chk($sformatf("rst_dat%0d", i), dout[i], 32'd0);
    end
    reset = 1'b0;

    // Abort a write by resetting in the second wait cycle.
    do_txn(0, 1'b1, 32'h10, 2'b00, 32'h1111_1111, '0, 1'b0, "w3_pre");
    do_txn(0, 1'b0, 32'h10, 2'b00, '0, 32'h1111_1111, 1'b0, "w3_rd0");
    @(negedge Clk);
    wr = 1'b1; Address = 32'h10; Size = 2'b00; Datain = 32'hDEAD_BEEF; req_v[0] = 1'b1;
    @(posedge Clk);
    #1 req_v[0] = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (2) @(negedge Clk) if (rdy[0]) seen = 1'b1;
    chk("abort_rst_dat", dout[0], 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) mdout[i] = '0;
    repeat (6) @(negedge Clk) if (rdy[0]) seen = 1'b1;
    chk("abort_no_rdy", 32'(seen), 32'd0);
    do_txn(0, 1'b0, 32'h10, 2'b00, '0, 32'h1111_1111, 1'b0, "w3_rd1");

    // Size-aware accesses with two wait states.
    do_txn(1, 1'b1, 32'h40, 2'b00, 32'h1234_5678, '0, 1'b0, "w2_wr_word");
    do_txn(1, 1'b0, 32'h40, 2'b00, '0, 32'h1234_5678, 1'b0, "w2_rd_word");
    do_txn(1, 1'b1, 32'h41, 2'b01, 32'h0000_00AB, '0, 1'b0, "w2_wr_byte");
    do_txn(1, 1'b0, 32'h40, 2'b00, '0, 32'h12AB_5678, 1'b0, "w2_rd_w1");
    do_txn(1, 1'b0, 32'h41, 2'b01, '0, 32'h0000_00AB, 1'b0, "w2_rd_byte");
    do_txn(1, 1'b1, 32'h42, 2'b10, 32'h0000_CAFE, '0, 1'b0, "w2_wr_half");
    do_txn(1, 1'b0, 32'h42, 2'b10, '0, 32'h0000_CAFE, 1'b0, "w2_rd_half");
    do_txn(1, 1'b0, 32'h40, 2'b00, '0, 32'h12AB_CAFE, 1'b0, "w2_rd_w2");
    do_txn(1, 1'b1, 32'h43, 2'b10, 32'h0000_5555, '0, 1'b1, "w2_mis_wr");
    do_txn(1, 1'b0, 32'h42, 2'b00, '0, '0, 1'b1, "w2_mis_rd");
    do_txn(1, 1'b0, 32'h40, 2'b00, '0, 32'h12AB_CAFE, 1'b0, "w2_rd_w3");
    do_txn(1, 1'b0, 32'h43, 2'b01, '0, 32'h0000_00FE, 1'b0, "w2_rd_b3");
    do_txn(1, 1'b0, 32'h40, 2'b10, '0, 32'h0000_12AB, 1'b0, "w2_rd_h0");
    do_txn(1, 1'b0, 32'h40, 2'b11, '0, 32'h12AB_CAFE, 1'b0, "w2_rd_rsv");

    // Zero wait states: preload, then back-to-back reads with req held high.
    for (int j = 0; j < 4; j++)
      do_txn(2, 1'b1, 32'(4 * j), 2'b00, 32'hA000_0000 + 32'(j * 32'h1111), '0, 1'b0, "w0_pre");
    @(negedge Clk);
    wr = 1'b0; Size = 2'b00; Address = 32'h0; req_v[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push_exp(2, 1'b0, 32'hA000_0000 + 32'(j * 32'h1111), 1'b0);
      @(posedge Clk);
      @(negedge Clk);
      chk($sformatf("held_rdy%0d", j), 32'(rdy[2]), 32'd1);
      e = sb.pop_front();
      chk($sformatf("held_dat%0d", j), dout[2], e.dat);
      chk($sformatf("held_mis%0d", j), 32'(mis[2]), 32'(e.mis));
      Address = 32'(4 * (j + 1));
      @(negedge Clk);
      chk($sformatf("held_gap%0d", j), 32'(rdy[2]), 32'd0);
    end
    req_v[2] = 1'b0;
    do_txn(2, 1'b0, 32'h400, 2'b00, '0, 32'hA000_0000, 1'b0, "w0_alias");

    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle datapath's memory port. It accepts one request per handshake from the CPU's memory initiator, applies programmable wait states, performs word/byte/halfword reads and writes on a byte-addressed big-endian array, and returns a zero-extended read word with a one-cycle `ready` pulse. It replaces a fixed-latency memory when stalls or size-aware accesses must be modelled.

## Interface
- `DEPTH_WORDS`, 256: array size in 32-bit words; power of two.
- `WAIT_CYCLES`, 1: wait states inserted between request capture and response; 0 is legal.
- `Clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid; sampled only in IDLE.
- `wr`  in  1  1 = write, 0 = read.
- `Address`  in  32  byte address.
- `Size`  in  2  00 word, 01 byte, 10 halfword, 11 reserved (treated as word).
- `Datain`  in  32  write data, right-justified for byte/halfword.
- `Dataout`  out  32  read data, zero-extended, right-justified.
- `ready`  out  1  one-cycle response pulse.
- `misaligned`  out  1  asserted with `ready` when the request was misaligned.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on `req`=1 capture `wr`, `Address`, `Size`, `Datain`; go to WAIT if `WAIT_CYCLES`>0, else RESP.
- WAIT: down-counter loaded with `WAIT_CYCLES`-1 on capture; go to RESP when it reaches 0.
- Commit point: the edge entering RESP. Writes update the array here; reads load `Dataout` here.
- RESP: `ready`=1 for exactly one cycle, then IDLE unconditionally.
- Byte order big-endian: byte lane 0 = `Address[1:0]`=00 = bits 31:24.
- Word index = `Address[log2(DEPTH_WORDS)+1:2]`; upper bits ignored (address wraps modulo array size).
- Byte write touches one lane; halfword write two lanes (`Address[1]` selects upper/lower half); word write all four.
- Reads: byte → {24'd0, lane}; halfword → {16'd0, half}; word → full word.
- Misaligned: halfword with `Address[0]`=1, word with `Address[1:0]`≠00. No array write; `Dataout`=0; `misaligned`=1 with `ready`.
- `req` asserted in WAIT or RESP is ignored; an initiator holding `req` through RESP starts a new transaction in the following IDLE cycle.
- Array contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `ready`=0, `misaligned`=0, `Dataout`=0, counter 0.
- Latency: `req` sampled at edge k → `ready` high during cycle k+1+`WAIT_CYCLES`.
- Throughput: one transaction per `WAIT_CYCLES`+2 cycles with `req` held high.
- `Dataout` holds its value until the next read or misaligned commit; writes leave it unchanged.
- Reset during WAIT aborts the transaction with no array write. Reset in the same cycle as the commit edge takes priority for state and outputs; the array write at that edge is not guaranteed.
- Read-after-write to the same address in back-to-back transactions returns the new data.

## Structure
- Shared package `mem_pkg`: `mem_size_t` enum (WORD=0, BYTE=1, HALF=2), `resp_state_t` enum (IDLE, WAIT, RESP), big-endian lane-select helper function.
- One sub-module, `byte_lane_ram`: four 8-bit-wide arrays of `DEPTH_WORDS` entries, per-lane write enables, synchronous write and read at the commit edge.
- The FSM, counter, alignment check and lane steering live in `mem_responder`.

## Test plan
- Reset mid-WAIT (`WAIT_CYCLES`=3): write 0xDEADBEEF to 0x10, assert `reset` in the second WAIT cycle → no `ready`; a subsequent word read of 0x10 returns the prior content.
- Word write 0x12345678 to 0x40, then word read of 0x40 with `WAIT_CYCLES`=2 → `ready` exactly 3 cycles after the read request edge, `Dataout`=0x12345678.
- Byte write 0xAB to 0x41, then read word 0x40 → 0x12AB5678; byte read of 0x41 → 0x000000AB.
- Halfword write 0xCAFE to 0x42, then halfword read 0x42 → 0x0000CAFE; word read 0x40 → 0x12ABCAFE.
- Misaligned halfword write to 0x43 and word read of 0x42 → each gives `ready`=1, `misaligned`=1, `Dataout`=0; word 0x40 stays 0x12ABCAFE.
- `WAIT_CYCLES`=0, `req` held high for 4 reads of 0x0, 0x4, 0x8, 0xC → `ready` pulses every 2 cycles; address 0x400 (`DEPTH_WORDS`=256) aliases to 0x0.
